// File: rtl/tt_pfd.sv
// ----------------------------------------------------------------------------
// tt_pfd -- sampled digital phase-frequency detector
//
// Synchronises the reference clock and the divided feedback clock into the
// i_clk_gen domain, detects their rising edges and runs a tri-state
// (IDLE/UP/DN) FSM whose state drives the up/down pulses for the loop filter.
// Also reports cycle slips and pulse-width timeouts and, optionally, lock.
//
// Optional feature macro:
//   TT_PFD_LOCK_DET_EN  defined   -> lock counter and o_locked logic built
//                       undefined -> no lock counter, o_locked tied to 0
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on i_ref / i_fb (>= 2)
//   CNT_W        pulse-width counter width (>= 2)
//   MAX_WIDTH    pulse-width timeout in cycles (<= 2^CNT_W - 1)
//   LOCK_TOL     largest pulse width counted as an in-tolerance comparison
//   LOCK_COUNT   consecutive in-tolerance comparisons needed for lock
//
// Ports:
//   i_clk_gen   in   sampling clock
//   i_rst       in   asynchronous active-high reset
//   i_ref       in   reference clock (asynchronous)
//   i_fb        in   divided feedback clock (asynchronous)
//   o_up        out  reference edge waiting for its feedback edge
//   o_down      out  feedback edge waiting for its reference edge
//   o_slip      out  one-cycle pulse on cycle slip or timeout
//   o_locked    out  lock indicator
//   i_scan_en   in   scan shift enable (counter becomes a shift register)
//   i_scan_in   in   scan data in
//   o_scan_out  out  scan data out (counter MSB)
// ----------------------------------------------------------------------------
module tt_pfd #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_WIDTH   = 255,
  parameter int unsigned LOCK_TOL    = 1,
  parameter int unsigned LOCK_COUNT  = 16
) (
  input  logic i_clk_gen,
  input  logic i_rst,
  input  logic i_ref,
  input  logic i_fb,
  output logic o_up,
  output logic o_down,
  output logic o_slip,
  output logic o_locked,
  input  logic i_scan_en,
  input  logic i_scan_in,
  output logic o_scan_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DN   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ref_sync;
  logic [SYNC_STAGES-1:0] fb_sync;
  logic                   ref_prev;
  logic                   fb_prev;
  logic                   ref_rise;
  logic                   fb_rise;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   slip_c;
  logic                   slip_q;

  // Synchronisers and edge-detect flops keep sampling even in scan mode
  always_ff @(posedge i_clk_gen or posedge i_rst) begin
    if (i_rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_prev <= 1'b0;
      fb_prev  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], i_ref};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], i_fb};
      ref_prev <= ref_sync[SYNC_STAGES-1];
      fb_prev  <= fb_sync[SYNC_STAGES-1];
    end
  end

  // Rising edges; discarded while scanning so the FSM and lock logic hold
  assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_prev & ~i_scan_en;
  assign fb_rise  = fb_sync[SYNC_STAGES-1]  & ~fb_prev  & ~i_scan_en;

  // State, pulse-width counter and slip register
  always_ff @(posedge i_clk_gen or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      slip_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      slip_q <= slip_c;
    end
  end

  // Next-state / counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slip_c    = 1'b0;
    if (i_scan_en) begin
      cnt_nxt = {cnt[CNT_W-2:0], i_scan_in};
    end else begin
      case (state)
        S_IDLE: begin
          // Coincident edges leave the FSM idle (a width-0 comparison)
          if (ref_rise && !fb_rise) begin
            state_nxt = S_UP;
            cnt_nxt   = CNT_ONE;
          end else if (fb_rise && !ref_rise) begin
            state_nxt = S_DN;
            cnt_nxt   = CNT_ONE;
          end
        end
        S_UP: begin
          if (fb_rise) begin
            // Closing edge; a simultaneous ref edge opens the next comparison
            if (ref_rise) begin
              cnt_nxt = CNT_ONE;
            end else begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end else if (ref_rise) begin
            cnt_nxt = CNT_ONE;
            slip_c  = 1'b1;
          end else if (cnt >= CNT_MAX) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            slip_c    = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_DN: begin
          if (ref_rise) begin
            if (fb_rise) begin
              cnt_nxt = CNT_ONE;
            end else begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end else if (fb_rise) begin
            cnt_nxt = CNT_ONE;
            slip_c  = 1'b1;
          end else if (cnt >= CNT_MAX) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            slip_c    = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pulse outputs decoded from the state register and blanked during scan
  assign o_up       = (state == S_UP) & ~i_scan_en;
  assign o_down     = (state == S_DN) & ~i_scan_en;
  assign o_slip     = slip_q & ~i_scan_en;
  assign o_scan_out = cnt[CNT_W-1];

`ifdef TT_PFD_LOCK_DET_EN
  localparam int unsigned     LOCK_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  TOL      = CNT_W'(LOCK_TOL);

  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_nxt;
  logic              locked_q;
  logic              close_c;
  logic [CNT_W-1:0]  width_c;

  // Identify a comparison closing this cycle and its pulse width
  always_comb begin
    close_c = 1'b0;
    width_c = '0;
    case (state)
      S_IDLE: begin
        if (ref_rise && fb_rise) begin
          close_c = 1'b1;
        end
      end
      S_UP: begin
        if (fb_rise) begin
          close_c = 1'b1;
          width_c = cnt;
        end
      end
      S_DN: begin
        if (ref_rise) begin
          close_c = 1'b1;
          width_c = cnt;
        end
      end
      default: begin
        close_c = 1'b0;
      end
    endcase
  end

  // Lock counter: saturating count of consecutive good comparisons
  always_comb begin
    lock_nxt = lock_cnt;
    if (slip_c) begin
      lock_nxt = '0;
    end else if (close_c) begin
      if (width_c <= TOL) begin
        if (lock_cnt != LOCK_MAX) begin
          lock_nxt = lock_cnt + LOCK_W'(1);
        end
      end else begin
        lock_nxt = '0;
      end
    end
  end

  always_ff @(posedge i_clk_gen or posedge i_rst) begin
    if (i_rst) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else begin
      lock_cnt <= lock_nxt;
      locked_q <= (lock_nxt == LOCK_MAX);
    end
  end

  assign o_locked = locked_q;
`else
  assign o_locked = 1'b0;
`endif

endmodule

// File: tb/tb_tt_pfd.sv
// ----------------------------------------------------------------------------
// tb_tt_pfd -- directed self-checking bench for tt_pfd
// DUT built with SYNC_STAGES=2, CNT_W=8, MAX_WIDTH=10, LOCK_TOL=1,
// LOCK_COUNT=16. Inputs change 1 ns after a rising clock edge; outputs are
// sampled at that same point, i.e. away from the active edge.
// ----------------------------------------------------------------------------
module tb_tt_pfd;

`ifdef TT_PFD_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ref_in;
  logic fb_in;
  logic scan_en;
  logic scan_in;
  logic up;
  logic down;
  logic slip;
  logic locked;
  logic scan_out;

  int checks = 0;
  int errors = 0;

  tt_pfd #(
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .MAX_WIDTH  (10),
    .LOCK_TOL   (1),
    .LOCK_COUNT (16)
  ) dut (
    .i_clk_gen (clk),
    .i_rst     (rst),
    .i_ref     (ref_in),
    .i_fb      (fb_in),
    .o_up      (up),
    .o_down    (down),
    .o_slip    (slip),
    .o_locked  (locked),
    .i_scan_en (scan_en),
    .i_scan_in (scan_in),
    .o_scan_out(scan_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ref_in = 1'b0; fb_in = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    repeat (3) tick();
    checks++; if (up !== 1'b0) begin errors++; $display("FAIL reset_up: got %b expected 0", up); end
    checks++; if (down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b expected 0", down); end
    checks++; if (slip !== 1'b0) begin errors++; $display("FAIL reset_slip: got %b expected 0", slip); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (scan_out !== 1'b0) begin errors++; $display("FAIL reset_scan_out: got %b expected 0", scan_out); end
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (up !== 1'b0 || down !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got up=%b down=%b expected 0 0", up, down); end
  endtask

  // ref rises 3 cycles before fb -> 3-cycle up pulse after a 2-cycle latency
  task automatic test_ref_lead();
    logic exp_up;
    ref_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_up = (i >= 3 && i <= 5);
      checks++; if (up !== exp_up) begin errors++; $display("FAIL ref_lead_up[%0d]: got %b expected %b", i, up, exp_up); end
      checks++; if (down !== 1'b0) begin errors++; $display("FAIL ref_lead_down[%0d]: got %b expected 0", i, down); end
      checks++; if (slip !== 1'b0) begin errors++; $display("FAIL ref_lead_slip[%0d]: got %b expected 0", i, slip); end
      if (i == 3) fb_in = 1'b1;
    end
    ref_in = 1'b0; fb_in = 1'b0;
    repeat (4) tick();
  endtask

  // 16 coincident edges: no pulses, lock one cycle after the 16th
  task automatic test_coincident();
    logic exp_lock;
    for (int it = 0; it < 16; it++) begin
      ref_in = 1'b1; fb_in = 1'b1;
      for (int j = 1; j <= 6; j++) begin
        tick();
        exp_lock = LOCK_EN && (it == 15) && (j >= 3);
        checks++; if (up !== 1'b0 || down !== 1'b0) begin errors++; $display("FAIL coinc_pulse[%0d.%0d]: got up=%b down=%b expected 0 0", it, j, up, down); end
        checks++; if (slip !== 1'b0) begin errors++; $display("FAIL coinc_slip[%0d.%0d]: got %b expected 0", it, j, slip); end
        checks++; if (locked !== exp_lock) begin errors++; $display("FAIL coinc_locked[%0d.%0d]: got %b expected %b", it, j, locked, exp_lock); end
        if (j == 3) begin ref_in = 1'b0; fb_in = 1'b0; end
      end
    end
  endtask

  // fb leads ref by 5 cycles while locked -> 5-cycle down pulse, lock lost
  task automatic test_fb_lead();
    logic exp_down;
    logic exp_lock;
    fb_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_down = (i >= 3 && i <= 7);
      exp_lock = LOCK_EN && (i < 8);
      checks++; if (down !== exp_down) begin errors++; $display("FAIL fb_lead_down[%0d]: got %b expected %b", i, down, exp_down); end
      checks++; if (up !== 1'b0) begin errors++; $display("FAIL fb_lead_up[%0d]: got %b expected 0", i, up); end
      checks++; if (locked !== exp_lock) begin errors++; $display("FAIL fb_lead_locked[%0d]: got %b expected %b", i, locked, exp_lock); end
      if (i == 5) ref_in = 1'b1;
    end
    ref_in = 1'b0; fb_in = 1'b0;
    repeat (4) tick();
  endtask

  // Second ref rise without fb -> slip, counter restarts at 1, then timeout
  task automatic test_slip();
    logic exp_up;
    logic exp_slip;
    ref_in = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      exp_up   = (i >= 3 && i <= 18);
      exp_slip = (i == 9 || i == 19);
      checks++; if (up !== exp_up) begin errors++; $display("FAIL slip_up[%0d]: got %b expected %b", i, up, exp_up); end
      checks++; if (slip !== exp_slip) begin errors++; $display("FAIL slip_pulse[%0d]: got %b expected %b", i, slip, exp_slip); end
      checks++; if (down !== 1'b0) begin errors++; $display("FAIL slip_down[%0d]: got %b expected 0", i, down); end
      if (i == 3)  ref_in = 1'b0;
      if (i == 6)  ref_in = 1'b1;
      if (i == 12) ref_in = 1'b0;
    end
  endtask

  // ref high, fb never rises -> up for MAX_WIDTH=10 cycles, then slip
  task automatic test_timeout();
    logic exp_up;
    logic exp_slip;
    ref_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_up   = (i >= 3 && i <= 12);
      exp_slip = (i == 13);
      checks++; if (up !== exp_up) begin errors++; $display("FAIL timeout_up[%0d]: got %b expected %b", i, up, exp_up); end
      checks++; if (slip !== exp_slip) begin errors++; $display("FAIL timeout_slip[%0d]: got %b expected %b", i, slip, exp_slip); end
      if (i == 14) ref_in = 1'b0;
    end
    repeat (4) tick();
  endtask

  // Shift A5 in and out through the counter, then reset mid-shift
  task automatic test_scan();
    logic [7:0] data;
    data = 8'hA5;
    scan_en = 1'b1;
    ref_in  = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      scan_in = data[i];
      tick();
      checks++; if (up !== 1'b0 || down !== 1'b0 || slip !== 1'b0) begin errors++; $display("FAIL scan_in_quiet[%0d]: got up=%b down=%b slip=%b expected 0 0 0", i, up, down, slip); end
    end
    for (int i = 7; i >= 0; i--) begin
      checks++; if (scan_out !== data[i]) begin errors++; $display("FAIL scan_out_bit[%0d]: got %b expected %b", i, scan_out, data[i]); end
      scan_in = 1'b0;
      tick();
      checks++; if (up !== 1'b0 || down !== 1'b0) begin errors++; $display("FAIL scan_out_quiet[%0d]: got up=%b down=%b expected 0 0", i, up, down); end
    end
    scan_in = 1'b1;
    repeat (8) tick();
    checks++; if (scan_out !== 1'b1) begin errors++; $display("FAIL scan_ones: got %b expected 1", scan_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (scan_out !== 1'b0) begin errors++; $display("FAIL scan_reset_out: got %b expected 0", scan_out); end
    tick();
    rst = 1'b0; scan_en = 1'b0; scan_in = 1'b0; ref_in = 1'b0;
    repeat (4) tick();
    checks++; if (up !== 1'b0 || down !== 1'b0) begin errors++; $display("FAIL scan_exit_idle: got up=%b down=%b expected 0 0", up, down); end
  endtask

  // Asynchronous reset mid-pulse, and an input already high at release
  task automatic test_reset_mid_pulse();
    logic exp_down;
    ref_in = 1'b1;
    repeat (4) tick();
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL mid_pulse_up: got %b expected 1", up); end
    #2 rst = 1'b1;
    #1;
    checks++; if (up !== 1'b0) begin errors++; $display("FAIL mid_pulse_reset_up: got %b expected 0", up); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_pulse_reset_locked: got %b expected 0", locked); end
    tick();
    ref_in = 1'b0; fb_in = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_down = (i >= 3);
      checks++; if (down !== exp_down) begin errors++; $display("FAIL release_high_down[%0d]: got %b expected %b", i, down, exp_down); end
    end
    ref_in = 1'b1;
    repeat (4) tick();
    checks++; if (down !== 1'b0 || up !== 1'b0) begin errors++; $display("FAIL release_high_close: got up=%b down=%b expected 0 0", up, down); end
    ref_in = 1'b0; fb_in = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; ref_in = 1'b0; fb_in = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    test_reset();
    test_ref_lead();
    test_coincident();
    test_fb_lead();
    test_slip();
    test_timeout();
    test_scan();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
